// File: rtl/seqdet_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seqdet_stream_ctrl
// Function : Sequencing controller for the 8-bit serial sequence detector.
//            Owns the detector's pattern, serial input and clear. On start it
//            clears the detector, streams a word MSB first, and counts dc hits.
// Options  : SQCTRL_FIRSTPOS_EN adds first_vld/first_pos outputs.
// Revision : 1.0 - initial release
// ============================================================================
module seqdet_stream_ctrl #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   input  logic [7:0]        pat_in,
   input  logic              pat_we,
   input  logic              dc,
   output logic [7:0]        setd,
   output logic              ds,
   output logic              det_clrn,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  hits
`ifdef SQCTRL_FIRSTPOS_EN
   ,
   output logic              first_vld,
   output logic [5:0]        first_pos
`endif
);

   localparam logic [5:0] c_LAST_IDX = 6'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_sh;
   logic [DATA_W-1:0]   w_sh_nxt;
   logic [5:0]          r_idx;
   logic [5:0]          w_idx_nxt;
   logic [7:0]          w_setd_nxt;
   logic                w_ds_nxt;
   logic                w_det_clrn_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic [CNT_W-1:0]    w_hits_nxt;
`ifdef SQCTRL_FIRSTPOS_EN
   logic                w_first_vld_nxt;
   logic [5:0]          w_first_pos_nxt;
`endif

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state   <= S_IDLE;
         r_sh      <= '0;
         r_idx     <= '0;
         setd      <= 8'h00;
         ds        <= 1'b0;
         det_clrn  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hits      <= '0;
`ifdef SQCTRL_FIRSTPOS_EN
         first_vld <= 1'b0;
         first_pos <= 6'd0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_sh      <= w_sh_nxt;
         r_idx     <= w_idx_nxt;
         setd      <= w_setd_nxt;
         ds        <= w_ds_nxt;
         det_clrn  <= w_det_clrn_nxt;
         busy      <= w_busy_nxt;
         done      <= w_done_nxt;
         hits      <= w_hits_nxt;
`ifdef SQCTRL_FIRSTPOS_EN
         first_vld <= w_first_vld_nxt;
         first_pos <= w_first_pos_nxt;
`endif
      end
   end

   // Every output is the registered image of the state it describes, so each
   // branch below sets up what the *next* cycle must present.
   always_comb begin
      w_state_nxt     = r_state;
      w_sh_nxt        = r_sh;
      w_idx_nxt       = r_idx;
      w_setd_nxt      = setd;
      w_ds_nxt        = 1'b0;
      w_det_clrn_nxt  = 1'b1;
      w_busy_nxt      = 1'b0;
      w_done_nxt      = 1'b0;
      w_hits_nxt      = hits;
`ifdef SQCTRL_FIRSTPOS_EN
      w_first_vld_nxt = first_vld;
      w_first_pos_nxt = first_pos;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (pat_we) begin
               w_setd_nxt = pat_in;
            end
            if (start) begin
               w_state_nxt     = S_CLEAR;
               w_sh_nxt        = din;
               w_hits_nxt      = '0;
               w_det_clrn_nxt  = 1'b0;
               w_busy_nxt      = 1'b1;
`ifdef SQCTRL_FIRSTPOS_EN
               w_first_vld_nxt = 1'b0;
               w_first_pos_nxt = 6'd0;
`endif
            end
         end
         S_CLEAR: begin
            // First serial bit leaves the register as SHIFT begins.
            w_state_nxt = S_SHIFT;
            w_busy_nxt  = 1'b1;
            w_idx_nxt   = 6'd0;
            w_ds_nxt    = r_sh[DATA_W-1];
            w_sh_nxt    = r_sh << 1;
         end
         S_SHIFT: begin
            w_busy_nxt = 1'b1;
            if (dc) begin
               if (hits != {CNT_W{1'b1}}) begin
                  w_hits_nxt = hits + CNT_W'(1);
               end
`ifdef SQCTRL_FIRSTPOS_EN
               if (!first_vld) begin
                  w_first_vld_nxt = 1'b1;
                  w_first_pos_nxt = r_idx;
               end
`endif
            end
            if (r_idx == c_LAST_IDX) begin
               w_state_nxt = S_DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_idx_nxt   = 6'd0;
            end else begin
               w_idx_nxt = r_idx + 6'd1;
               w_ds_nxt  = r_sh[DATA_W-1];
               w_sh_nxt  = r_sh << 1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/seqdet_stream_ctrl.md
Name: seqdet_stream_ctrl

Overview:
Sequencing controller for the 8-bit serial sequence detector.
- Holds the detector's pattern register (setd).
- On command, clears the detector, then streams a parallel data word into it one bit per clock, MSB first.
- Counts the detector's dc pulses and reports a hit count with a start/busy/done handshake.
- Sits between the host/register interface and the detector instance; owns that detector's ds, setd and clrn inputs.

Parameters:
DATA_W, 16, number of bits streamed per run (legal range 8..64).
CNT_W, 4, width of the hit counter; the counter saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock, all state changes on the rising edge
clrn  input  1  asynchronous active-low reset
start  input  1  run request, sampled only in IDLE
din  input  DATA_W  word to stream, captured on accepted start
pat_in  input  8  new detector pattern
pat_we  input  1  pattern write strobe, honoured only in IDLE
dc  input  1  detect flag from the detector, combinational, valid in the cycle ds is presented
setd  output  8  pattern register driven to the detector
ds  output  1  serial bit to the detector
det_clrn  output  1  registered active-low clear to the detector's clrn
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the run completes
hits  output  CNT_W  detections counted in the last or current run

Behaviour:
- Reset (clrn=0, asynchronous), all outputs and state forced:
  - state=IDLE, setd=8'h00, ds=0, det_clrn=0, busy=0, done=0, hits=0, shift register=0, bit index=0.
  - The detector is held cleared for the whole reset.
  - Reset mid-run aborts immediately; no done pulse is produced.
- All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE:
  - det_clrn=1, ds=0, busy=0.
  - pat_we=1 loads setd<=pat_in on the next edge.
  - If pat_we and start are both high in the same cycle, the pattern write happens and start is still accepted; the run uses the new pattern.
  - start=1: capture din into the shift register, clear hits to 0, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - det_clrn=0, ds=0, busy=1.
  - The detector is forced to state 0, and is still cleared at the edge leaving CLEAR.
  - Go to SHIFT with bit index 0.
- SHIFT (exactly DATA_W cycles):
  - det_clrn=1, busy=1.
  - ds = shift register MSB; the register shifts left by 1 each edge.
  - On each edge, if dc=1 then hits<=hits+1, saturating at all-ones.
  - After the edge sampling bit index DATA_W-1, go to DONE.
- DONE (1 cycle):
  - done=1, busy=0, ds=0; hits holds the final value.
  - Next state IDLE.
- Ignored inputs:
  - start outside IDLE is ignored, not queued.
  - pat_we outside IDLE is ignored; setd is stable for a whole run.
- Latency: start sampled at edge N gives CLEAR during cycle N+1, SHIFT during cycles N+2..N+DATA_W+1, and done during cycle N+DATA_W+2.
- hits holds its value through IDLE until the next accepted start.
- dc is ignored outside SHIFT.
- Detector semantics are non-overlapping: after a detect or a mismatch it restarts from state 0. The controller does not compensate for this; hits reports exactly the dc pulses seen.

Optional Feature:
Macro SQCTRL_FIRSTPOS_EN.
- Defined: adds outputs first_vld (1 bit) and first_pos (6 bits).
  - On accepted start, both are cleared.
  - On the first SHIFT cycle with dc=1, first_pos<=bit index and first_vld<=1.
  - Both hold until the next accepted start; reset value is 0.
- Not defined: these ports and their registers do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset: assert clrn=0 mid-SHIFT (pattern A5, run active) -> all outputs 0 immediately, det_clrn=0; no done pulse; after release the block is in IDLE with det_clrn=1 one edge later.
- Basic run: pat_we with pat_in=8'hA5, then start with din=16'hA5A5 -> busy for 17 cycles; dc seen at SHIFT indices 7 and 15; done pulses at start+18; hits=2 (first_pos=7 if enabled).
- Broken prefix: pattern 8'hFF, din=16'hFEFF -> hits=1 (first_pos=15); mismatch at index 7 restarts the detector.
- Saturation: CNT_W=1, pattern 8'h00, din=16'h0000 -> hits=1, not 0 after wrap.
- Ignored requests: pulse start and pat_we (pat_in=8'h3C) during SHIFT of the basic run -> no restart, setd stays A5, hits=2; a start in IDLE afterwards runs normally.
- Same-cycle write and start: pat_we=1 with pat_in=8'h0F, start=1, din=16'h0F00 -> run uses 8'h0F, hits=1.
